matrix_scalar_divide_iter: RTL and testbench
============================================

Name: matrix_scalar_divide_iter

Overview:
Divides every complex element of a MAT_HEIGHT x MAT_WIDTH matrix by a runtime unsigned divisor, with selectable truncate or round mode. The whole matrix arrives as one AXI-stream beat and leaves as one beat. It is the runtime-divisor successor to the fixed-SCALAR divider in the matrix pipeline. Division uses LANES shared iterative restoring dividers, trading latency for area, and flags divide-by-zero.

Parameters:
MAT_WIDTH, 4, matrix columns
MAT_HEIGHT, 4, matrix rows
ELEMENT_SIZE, 32, bits per complex element: real in [HALF-1:0], imag in [ELEMENT_SIZE-1:HALF], HALF=ELEMENT_SIZE/2, both signed two's complement
LANES, 4, elements divided in parallel; must divide N=MAT_WIDTH*MAT_HEIGHT
DIVISOR_SIZE, 16, divisor width, unsigned

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
s_axis_tdata  in  N*ELEMENT_SIZE  input matrix, element e at [e*ELEMENT_SIZE +: ELEMENT_SIZE]
s_axis_tdivisor  in  DIVISOR_SIZE  divisor, sampled with the beat
s_axis_tround  in  1  0 = truncate toward zero, 1 = round half away from zero
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  passed through
s_axis_tuser  in  1  passed through
s_axis_tready  out  1  input ready
m_axis_tdata  out  N*ELEMENT_SIZE  quotient matrix, same layout as the input
m_axis_tdz  out  1  divisor was zero for this beat
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  latched s_axis_tlast
m_axis_tuser  out  1  latched s_axis_tuser
m_axis_tready  in  1  downstream ready
busy  out  1  high in LOAD, DIV or OUT

Behaviour:
- Reset (synchronous, overrides all): state=IDLE; m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdz=0, busy=0.
- s_axis_tready is 0 while reset is high. Otherwise s_axis_tready=1 only in IDLE.
- State machine:
  - IDLE: on s_axis_tvalid&&s_axis_tready, latch data, divisor, round, tlast, tuser; group=0; go to LOAD.
  - LOAD (1 cycle): load |x| for 2*LANES parts of group (elements group*LANES .. +LANES-1). In round mode add divisor>>1 to each magnitude. Work width is HALF+1 bits. Go to DIV.
  - DIV (HALF+1 cycles, one restoring step per cycle, MSB first): after the last step, write signed quotients into the output register. If group<N/LANES-1, increment group and go to LOAD; else go to OUT.
  - OUT: m_axis_tvalid=1. On m_axis_tready go to IDLE, m_axis_tvalid=0 next cycle.
- Latency: m_axis_tvalid rises exactly LAT=(N/LANES)*(HALF+2) cycles after the accepting edge. Default is 4*18=72. LAT is fixed, including when the divisor is zero.
- Throughput: one matrix per LAT+1 cycles minimum; no overlap between matrices.
- Sign rule: q = sign(x)*floor(mag/d). mag=|x| when truncating; mag=|x|+(d>>1) when rounding. A zero result is +0.
- Range: -2^(HALF-1) is handled without overflow. |x| uses HALF+1 bits, so -32768/1 = -32768.
- Divisor zero: each part saturates by sign. Positive gives 2^(HALF-1)-1, negative gives -2^(HALF-1), zero gives 0. m_axis_tdz=1 for that beat, otherwise 0.
- Backpressure: while m_axis_tvalid&&!m_axis_tready, every m_axis_* output holds stable and s_axis_tready=0.
- s_axis_* inputs are ignored outside IDLE. Latched values are unaffected by input changes after accept.
- Reset in any state discards work in flight. s_axis_tready is 1 on the first cycle after reset falls.

Test Plan:
- Element 0 = 0x0A00F600 (imag 2560, real -2560), divisor 256, truncate -> element 0 = 0x000AFFF6; m_axis_tvalid rises 72 cycles after accept; tlast/tuser echoed.
- Real 384, imag -384, divisor 256: round=0 -> real 1, imag -1; round=1 -> real 2, imag -2; real 383 round=1 -> 1.
- Real 5, imag -5, third element 0, divisor 0 -> 0x7FFF, 0x8000, 0x0000; m_axis_tdz=1; latency still 72.
- Real -32768: divisor 1 -> -32768; divisor 65535 with round=0 -> 0, with round=1 -> -1 (0xFFFF).
- m_axis_tready held 0 for 20 cycles in OUT -> outputs constant, s_axis_tready=0; accept lands the cycle after ready=1, next input is accepted then.
- Reset asserted mid-DIV (group 2) -> next cycle m_axis_tvalid=0, busy=0; new matrix after release gives a correct result with no stale elements.

Source files
------------

// File: rtl/matrix_scalar_divide_iter.sv
// Divides each complex part of a whole-matrix beat by a runtime unsigned divisor,
// LANES elements at a time through shared restoring dividers; one matrix in flight.
module matrix_scalar_divide_iter #(
  parameter int MAT_WIDTH    = 4,
  parameter int MAT_HEIGHT   = 4,
  parameter int ELEMENT_SIZE = 32,
  parameter int LANES        = 4,
  parameter int DIVISOR_SIZE = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] s_axis_tdata,
  input  logic [DIVISOR_SIZE-1:0]                   s_axis_tdivisor,
  input  logic                                      s_axis_tround,
  input  logic                                      s_axis_tvalid,
  input  logic                                      s_axis_tlast,
  input  logic                                      s_axis_tuser,
  output logic                                      s_axis_tready,
  output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] m_axis_tdata,
  output logic                                      m_axis_tdz,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  output logic                                      m_axis_tuser,
  input  logic                                      m_axis_tready,
  output logic                                      busy
);
  localparam int N      = MAT_WIDTH * MAT_HEIGHT;
  localparam int HALF   = ELEMENT_SIZE / 2;
  localparam int W      = HALF + 1;
  localparam int DS     = DIVISOR_SIZE;
  localparam int PARTS  = 2 * LANES;
  localparam int GROUPS = N / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int SW     = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic [N*ELEMENT_SIZE-1:0] data_q;
  logic [N*ELEMENT_SIZE-1:0] tdata_q;
  logic [DS-1:0]           div_q;
  logic                    round_q;
  logic [GW-1:0]           group_q;
  logic [SW-1:0]           step_q;
  logic                    tvalid_q, tlast_q, tuser_q, tdz_q;
  logic [DS-1:0]           rem_q [PARTS];
  logic [W-1:0]            quo_q [PARTS];

  logic [HALF-1:0]         part_x   [PARTS];
  logic [W-1:0]            part_xs  [PARTS];
  logic [W-1:0]            mag_ld   [PARTS];
  logic [DS:0]             shifted  [PARTS];
  logic [DS-1:0]           diff     [PARTS];
  logic                    ge       [PARTS];
  logic [DS-1:0]           rem_d    [PARTS];
  logic [W-1:0]            quo_d    [PARTS];
  logic [HALF-1:0]         res      [PARTS];
  logic [W-1:0]            half_div;
  int                      part_base;
  logic                    accept, last_step, last_group;

  assign s_axis_tready = !reset && (state_q == S_IDLE);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_step     = (step_q == SW'(W - 1));
  assign last_group    = (group_q == GW'(GROUPS - 1));
  assign busy          = (state_q != S_IDLE);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tdz    = tdz_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: state_d = S_DIV;
      S_DIV:  if (last_step) state_d = last_group ? S_OUT : S_LOAD;
      S_OUT:  if (m_axis_tready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Parts of a group are contiguous HALF-wide slices: real/imag interleave per element.
  always_comb begin
    part_base = int'(group_q) * PARTS;
    half_div  = W'(div_q >> 1);
    for (int p = 0; p < PARTS; p++) begin
      part_x[p]  = data_q[(part_base + p)*HALF +: HALF];
      part_xs[p] = {part_x[p][HALF-1], part_x[p]};
      mag_ld[p]  = (part_x[p][HALF-1] ? -part_xs[p] : part_xs[p]) + (round_q ? half_div : '0);
      shifted[p] = {rem_q[p], quo_q[p][W-1]};
      ge[p]      = (shifted[p] >= {1'b0, div_q});
      diff[p]    = shifted[p][DS-1:0] - div_q;
      rem_d[p]   = ge[p] ? diff[p] : shifted[p][DS-1:0];
      quo_d[p]   = {quo_q[p][W-2:0], ge[p]};
      if (tdz_q) begin
        if (part_x[p][HALF-1])     res[p] = {1'b1, {(HALF-1){1'b0}}};
        else if (part_x[p] == '0) res[p] = '0;
        else                       res[p] = {1'b0, {(HALF-1){1'b1}}};
      end else begin
        res[p] = part_x[p][HALF-1] ? -quo_d[p][HALF-1:0] : quo_d[p][HALF-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tdz_q    <= 1'b0;
      group_q  <= '0;
      step_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          data_q  <= s_axis_tdata;
          div_q   <= s_axis_tdivisor;
          round_q <= s_axis_tround;
          tlast_q <= s_axis_tlast;
          tuser_q <= s_axis_tuser;
          tdz_q   <= (s_axis_tdivisor == '0);
          group_q <= '0;
        end
        S_LOAD: begin
          for (int p = 0; p < PARTS; p++) begin
            quo_q[p] <= mag_ld[p];
            rem_q[p] <= '0;
          end
          step_q <= '0;
        end
        S_DIV: begin
          for (int p = 0; p < PARTS; p++) begin
            quo_q[p] <= quo_d[p];
            rem_q[p] <= rem_d[p];
          end
          step_q <= step_q + SW'(1);
          if (last_step) begin
            for (int p = 0; p < PARTS; p++)
              tdata_q[(part_base + p)*HALF +: HALF] <= res[p];
            if (last_group) tvalid_q <= 1'b1;
            else            group_q  <= group_q + GW'(1);
          end
        end
        S_OUT: if (m_axis_tready) tvalid_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_scalar_divide_iter.sv
// Directed bench for matrix_scalar_divide_iter: hand-computed quotients, latency,
// divide-by-zero saturation, backpressure hold and mid-flight reset.
module tb_matrix_scalar_divide_iter;
  localparam int N   = 16;
  localparam int ES  = 32;
  localparam int LAT = 72;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*ES-1:0] s_axis_tdata;
  logic [15:0]   s_axis_tdivisor;
  logic          s_axis_tround, s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
  logic [N*ES-1:0] m_axis_tdata;
  logic          m_axis_tdz, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready, busy;

  int n_assert = 0;
  int n_fail   = 0;

  matrix_scalar_divide_iter dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tdivisor(s_axis_tdivisor),
    .s_axis_tround(s_axis_tround), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tdz(m_axis_tdz), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cpx(input int re, input int im);
    logic [15:0] r, i;
    r = 16'(re);
    i = 16'(im);
    return {i, r};
  endfunction

  function automatic logic [31:0] el(input int e);
    return m_axis_tdata[e*ES +: ES];
  endfunction

  task automatic send(input logic [N*ES-1:0] d, input logic [15:0] dv, input logic rnd,
                      input logic lst, input logic usr, output int waits);
    s_axis_tdata = d; s_axis_tdivisor = dv; s_axis_tround = rnd;
    s_axis_tlast = lst; s_axis_tuser = usr; s_axis_tvalid = 1'b1;
    waits = 0;
    while (!s_axis_tready && waits < 300) begin @(posedge clk); #1; waits++; end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '1; s_axis_tdivisor = 16'h0003;
    s_axis_tround = ~rnd; s_axis_tlast = ~lst; s_axis_tuser = ~usr;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!m_axis_tvalid && lat < 300) begin @(posedge clk); #1; lat++; end
  endtask

  logic [N*ES-1:0] mat1, mat2, mat3, mat4, mat6;
  int w, lat;
  logic hold_ok;

  initial begin
    reset = 1'b1; m_axis_tready = 1'b1;
    s_axis_tdata = '0; s_axis_tdivisor = '0; s_axis_tround = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata_zero", (m_axis_tdata == '0), 1);
    check("rst_busy", busy, 0);
    check("rst_sready", s_axis_tready, 0);
    check("rst_last_user_dz", {m_axis_tlast, m_axis_tuser, m_axis_tdz}, 3'b000);
    reset = 1'b0; #1;
    check("rst_release_sready", s_axis_tready, 1);

    // Basic truncation across several groups
    mat1 = '0;
    mat1[0*ES +: ES]  = 32'h0A00F600;
    mat1[5*ES +: ES]  = cpx(-255, 256);
    mat1[15*ES +: ES] = cpx(1000, -1000);
    send(mat1, 16'd256, 1'b0, 1'b1, 1'b0, w);
    check("t1_busy", busy, 1);
    wait_out(lat);
    check("t1_latency", lat, LAT);
    check("t1_el0", el(0), 32'h000AFFF6);
    check("t1_el5", el(5), 32'h00010000);
    check("t1_el15", el(15), 32'hFFFD0003);
    check("t1_last_user_dz", {m_axis_tlast, m_axis_tuser, m_axis_tdz}, 3'b100);
    @(posedge clk); #1;
    check("t1_tvalid_drop", m_axis_tvalid, 0);
    check("t1_idle", {busy, s_axis_tready}, 2'b01);

    // Truncate versus round
    mat2 = '0;
    mat2[0*ES +: ES] = cpx(384, -384);
    mat2[1*ES +: ES] = cpx(383, 0);
    mat2[2*ES +: ES] = cpx(127, 128);
    send(mat2, 16'd256, 1'b0, 1'b0, 1'b1, w);
    wait_out(lat);
    check("t2_trunc_el0", el(0), 32'hFFFF0001);
    check("t2_trunc_el1", el(1), 32'h00000001);
    check("t2_trunc_el2", el(2), 32'h00000000);
    check("t2_last_user", {m_axis_tlast, m_axis_tuser}, 2'b01);
    @(posedge clk); #1;
    send(mat2, 16'd256, 1'b1, 1'b0, 1'b0, w);
    wait_out(lat);
    check("t2_round_el0", el(0), 32'hFFFE0002);
    check("t2_round_el1", el(1), 32'h00000001);
    check("t2_round_el2", el(2), 32'h00010000);
    @(posedge clk); #1;

    // Divide by zero saturates by sign
    mat3 = '0;
    mat3[0*ES +: ES] = cpx(5, -5);
    mat3[2*ES +: ES] = cpx(-1, 1);
    send(mat3, 16'd0, 1'b0, 1'b0, 1'b0, w);
    wait_out(lat);
    check("t3_latency", lat, LAT);
    check("t3_el0", el(0), 32'h80007FFF);
    check("t3_el1", el(1), 32'h00000000);
    check("t3_el2", el(2), 32'h7FFF8000);
    check("t3_dz", m_axis_tdz, 1);
    @(posedge clk); #1;

    // Extreme magnitudes
    mat4 = '0;
    mat4[0*ES +: ES] = 32'h7FFF8000;
    send(mat4, 16'd1, 1'b0, 1'b0, 1'b0, w);
    wait_out(lat);
    check("t4_div1", el(0), 32'h7FFF8000);
    check("t4_dz_clear", m_axis_tdz, 0);
    @(posedge clk); #1;
    send(mat4, 16'hFFFF, 1'b0, 1'b0, 1'b0, w);
    wait_out(lat);
    check("t4_big_trunc", el(0), 32'h00000000);
    @(posedge clk); #1;
    send(mat4, 16'hFFFF, 1'b1, 1'b0, 1'b0, w);
    wait_out(lat);
    check("t4_big_round", el(0), 32'h0000FFFF);
    @(posedge clk); #1;

    // Backpressure hold in OUT, then back-to-back accept
    m_axis_tready = 1'b0;
    send(mat1, 16'd256, 1'b0, 1'b0, 1'b1, w);
    wait_out(lat);
    check("t5_latency", lat, LAT);
    s_axis_tdata = mat3; s_axis_tdivisor = 16'd0; s_axis_tvalid = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!(m_axis_tvalid === 1'b1 && el(0) === 32'h000AFFF6 && el(15) === 32'hFFFD0003 &&
            m_axis_tuser === 1'b1 && m_axis_tlast === 1'b0 && m_axis_tdz === 1'b0 &&
            s_axis_tready === 1'b0))
        hold_ok = 1'b0;
    end
    check("t5_hold_stable", hold_ok, 1);
    m_axis_tready = 1'b1;
    send(mat3, 16'd0, 1'b0, 1'b0, 1'b0, w);
    check("t5_accept_wait", w, 1);
    wait_out(lat);
    check("t5_next_latency", lat, LAT);
    check("t5_next_el0", el(0), 32'h80007FFF);
    check("t5_next_dz", m_axis_tdz, 1);
    @(posedge clk); #1;

    // Reset in the middle of group 2
    send(mat1, 16'd256, 1'b0, 1'b1, 1'b1, w);
    repeat (40) @(posedge clk);
    #1;
    check("t6_busy_mid", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_busy", busy, 0);
    reset = 1'b0; #1;
    check("t6_sready", s_axis_tready, 1);
    mat6 = '0;
    mat6[0*ES +: ES] = 32'h0A00F600;
    send(mat6, 16'd256, 1'b0, 1'b0, 1'b0, w);
    wait_out(lat);
    check("t6_latency", lat, LAT);
    check("t6_el0", el(0), 32'h000AFFF6);
    check("t6_el5", el(5), 32'h00000000);
    check("t6_el15", el(15), 32'h00000000);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
